// File: rtl/fwd_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard control slice: operand select
// codes, shadow pipeline entry layout and the register-match helper.
package fwd_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] SEL_BUS = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;
  localparam int N_STG   = 3;

  typedef struct packed {
    logic [REG_AW-1:0] rw;
    logic              regwr;
    logic              load;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '{rw: '0, regwr: 1'b0, load: 1'b0};

  // Register 0 is hardwired, so a producer targeting it never forwards.
  function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                     input logic [REG_AW-1:0] rw,
                                     input logic              regwr);
    return (r != '0) && regwr && (rw == r);
  endfunction

endpackage

// File: rtl/fwd_cmp.sv
// Compares one ID-stage source register against the EX and MEM shadow entries.
// match[1] is the EX (younger) hit, match[0] the MEM hit.
module fwd_cmp
  import fwd_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              ex_regwr,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic              mem_regwr,
  output logic [1:0]        match
);

  always_comb begin
    match    = 2'b00;
    match[1] = reg_match(src, ex_rw, ex_regwr);
    match[0] = reg_match(src, mem_rw, mem_regwr);
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding select generation and load-use / store-data hazard control,
// tracking destination info in a private EX/MEM/WB shadow pipeline.
module fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] rw_id,
  input  logic              use_rs_id,
  input  logic              use_rt_id,
  input  logic              regwr_id,
  input  logic              load_id,
  input  logic              imm_id,
  input  logic              flush,
  output logic [1:0]        ALUsrcA,
  output logic [1:0]        ALUsrcB,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  import fwd_ctrl_pkg::*;

  shadow_t          stage_q [N_STG];
  shadow_t          stage_d [N_STG];
  logic [1:0]       alu_src_a_q, alu_src_a_d;
  logic [1:0]       alu_src_b_q, alu_src_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] rs_match;
  logic [1:0] rt_match;
  logic       load_use;
  logic       store_data;
  logic       stall_int;
  logic       kill;

  fwd_cmp u_cmp_rs (
    .src       (rs_id),
    .ex_rw     (stage_q[STG_EX].rw),
    .ex_regwr  (stage_q[STG_EX].regwr),
    .mem_rw    (stage_q[STG_MEM].rw),
    .mem_regwr (stage_q[STG_MEM].regwr),
    .match     (rs_match)
  );

  fwd_cmp u_cmp_rt (
    .src       (rt_id),
    .ex_rw     (stage_q[STG_EX].rw),
    .ex_regwr  (stage_q[STG_EX].regwr),
    .mem_rw    (stage_q[STG_MEM].rw),
    .mem_regwr (stage_q[STG_MEM].regwr),
    .match     (rt_match)
  );

  // A store's data operand cannot be forwarded while B selects the immediate,
  // so it waits until its producer has left MEM.
  always_comb begin
    load_use   = (use_rs_id & rs_match[1] & stage_q[STG_EX].load) |
                 (use_rt_id & ~imm_id & rt_match[1] & stage_q[STG_EX].load);
    store_data = imm_id & use_rt_id & (rt_match[1] | rt_match[0]);
    stall_int  = load_use | store_data;
    kill       = stall_int | flush;
  end

  always_comb begin
    stage_d[STG_EX]  = '{rw: rw_id, regwr: regwr_id & ~kill, load: load_id & ~kill};
    stage_d[STG_MEM] = stage_q[STG_EX];
    stage_d[STG_WB]  = stage_q[STG_MEM];
  end

  // An EX hit means the producer will be in MEM when the consumer reaches EX.
  always_comb begin
    alu_src_a_d = SEL_BUS;
    alu_src_b_d = SEL_BUS;
    if (!kill) begin
      if (rs_match[1]) begin
        alu_src_a_d = SEL_MEM;
      end else if (rs_match[0]) begin
        alu_src_a_d = SEL_WB;
      end
      if (imm_id) begin
        alu_src_b_d = SEL_IMM;
      end else if (rt_match[1]) begin
        alu_src_b_d = SEL_MEM;
      end else if (rt_match[0]) begin
        alu_src_b_d = SEL_WB;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_STG; i++) begin
        stage_q[i] <= SHADOW_EMPTY;
      end
      alu_src_a_q <= SEL_BUS;
      alu_src_b_q <= SEL_BUS;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_STG; i++) begin
        stage_q[i] <= stage_d[i];
      end
      alu_src_a_q <= alu_src_a_d;
      alu_src_b_q <= alu_src_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ALUsrcA   = alu_src_a_q;
  assign ALUsrcB   = alu_src_b_q;
  assign stall     = stall_int;
  assign bubble    = kill;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Table-driven bench for fwd_ctrl: combinational stall/bubble checked in the
// driving cycle, registered selects checked one edge later via a scoreboard.
module tb_fwd_ctrl;

   typedef struct {
      string      name;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rw;
      logic       urs;
      logic       urt;
      logic       rwr;
      logic       ld;
      logic       imm;
      logic       fl;
      logic       xStall;
      logic       xBubble;
      logic [1:0] xA;
      logic [1:0] xB;
      int         xCnt;
   } vec_t;

   typedef struct {
      string      name;
      logic [1:0] a;
      logic [1:0] b;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rsId = '0;
   logic [4:0]  rtId = '0;
   logic [4:0]  rwId = '0;
   logic        useRsId = 1'b0;
   logic        useRtId = 1'b0;
   logic        regwrId = 1'b0;
   logic        loadId = 1'b0;
   logic        immId = 1'b0;
   logic        flushIn = 1'b0;

   logic [1:0]  aluSrcA, aluSrcB;
   logic        stallOut, bubbleOut;
   logic [31:0] stallCnt;

   logic [1:0]  aluSrcASat, aluSrcBSat;
   logic        stallSat, bubbleSat;
   logic [1:0]  stallCntSat;

   int compared = 0;
   int mismatched = 0;

   vec_t vecs[$];
   sb_t  sbQ[$];

   fwd_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .rs_id(rsId), .rt_id(rtId), .rw_id(rwId),
      .use_rs_id(useRsId), .use_rt_id(useRtId),
      .regwr_id(regwrId), .load_id(loadId), .imm_id(immId), .flush(flushIn),
      .ALUsrcA(aluSrcA), .ALUsrcB(aluSrcB),
      .stall(stallOut), .bubble(bubbleOut), .stall_cnt(stallCnt)
   );

   // Narrow counter copy so saturation is reachable in a short run.
   fwd_ctrl #(.REG_AW(5), .CNT_W(2)) dutSat (
      .clk(clk), .rst(rst),
      .rs_id(rsId), .rt_id(rtId), .rw_id(rwId),
      .use_rs_id(useRsId), .use_rt_id(useRtId),
      .regwr_id(regwrId), .load_id(loadId), .imm_id(immId), .flush(flushIn),
      .ALUsrcA(aluSrcASat), .ALUsrcB(aluSrcBSat),
      .stall(stallSat), .bubble(bubbleSat), .stall_cnt(stallCntSat)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rsId    = v.rs;
      rtId    = v.rt;
      rwId    = v.rw;
      useRsId = v.urs;
      useRtId = v.urt;
      regwrId = v.rwr;
      loadId  = v.ld;
      immId   = v.imm;
      flushIn = v.fl;
   endtask

   task automatic addVec(input string n, input int rs, input int rt, input int rw,
                         input bit urs, input bit urt, input bit rwr, input bit ld,
                         input bit imm, input bit fl, input bit xs, input bit xbub,
                         input int xa, input int xb, input int xcnt);
      vec_t v;
      v.name = n;
      v.rs = 5'(rs); v.rt = 5'(rt); v.rw = 5'(rw);
      v.urs = urs; v.urt = urt; v.rwr = rwr; v.ld = ld; v.imm = imm; v.fl = fl;
      v.xStall = xs; v.xBubble = xbub;
      v.xA = 2'(xa); v.xB = 2'(xb); v.xCnt = xcnt;
      vecs.push_back(v);
   endtask

   task automatic popCheck();
      sb_t e;
      if (sbQ.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = sbQ.pop_front();
         checkOutput({e.name, " ALUsrcA"}, 32'(aluSrcA), 32'(e.a));
         checkOutput({e.name, " ALUsrcB"}, 32'(aluSrcB), 32'(e.b));
      end
   endtask

   initial begin
      //      name        rs  rt  rw  urs urt rwr ld imm fl  stall bub A  B  cnt
      addVec("add3",      1,  2,  3,  1,  1,  1,  0, 0,  0,  0,    0,  0, 0, 0);
      addVec("sub4",      3,  5,  4,  1,  1,  1,  0, 0,  0,  0,    0,  1, 0, -1);
      addVec("nop",       0,  0,  0,  0,  0,  0,  0, 0,  0,  0,    0,  0, 0, -1);
      addVec("or6",       4,  7,  6,  1,  1,  1,  0, 0,  0,  0,    0,  2, 0, -1);
      addVec("lw8",       1,  0,  8,  1,  0,  1,  1, 1,  0,  0,    0,  0, 3, -1);
      addVec("add9stall", 8,  2,  9,  1,  1,  1,  0, 0,  0,  1,    1,  0, 0, 1);
      addVec("add9go",    8,  2,  9,  1,  1,  1,  0, 0,  0,  0,    0,  2, 0, 1);
      addVec("add5",      1,  2,  5,  1,  1,  1,  0, 0,  0,  0,    0,  0, 0, -1);
      addVec("sw1",       2,  5,  0,  1,  1,  0,  0, 1,  0,  1,    1,  0, 0, 2);
      addVec("sw2",       2,  5,  0,  1,  1,  0,  0, 1,  0,  1,    1,  0, 0, 3);
      addVec("swgo",      2,  5,  0,  1,  1,  0,  0, 1,  0,  0,    0,  0, 3, 3);
      addVec("wrR0",      1,  2,  0,  1,  1,  1,  0, 0,  0,  0,    0,  0, 0, -1);
      addVec("rdR0",      0,  0, 12,  1,  1,  0,  0, 0,  0,  0,    0,  0, 0, -1);
      addVec("lw10flush", 1,  0, 10,  1,  0,  1,  1, 1,  1,  0,    1,  0, 0, 3);
      addVec("add11",    10, 10, 11,  1,  1,  1,  0, 0,  0,  0,    0,  0, 0, 3);
      addVec("lw13",      1,  0, 13,  1,  0,  1,  1, 1,  0,  0,    0,  0, 3, -1);
      addVec("add14fl",  13,  2, 14,  1,  1,  1,  0, 0,  1,  1,    1,  0, 0, 4);
      addVec("add14",    13,  2, 14,  1,  1,  1,  0, 0,  0,  0,    0,  2, 0, 4);
      addVec("or15",      1, 14, 15,  1,  1,  1,  0, 0,  0,  0,    0,  0, 1, -1);
      addVec("and15",    14, 15, 15,  1,  1,  1,  0, 0,  0,  0,    0,  2, 1, -1);
      addVec("xor20",    15, 15, 20,  1,  1,  1,  0, 0,  0,  0,    0,  1, 1, -1);
      addVec("lw16",      1,  0, 16,  1,  0,  1,  1, 1,  0,  0,    0,  0, 3, -1);
      addVec("add17st",   2, 16, 17,  1,  1,  1,  0, 0,  0,  1,    1,  0, 0, 5);
      addVec("add17",     2, 16, 17,  1,  1,  1,  0, 0,  0,  0,    0,  0, 2, 5);
      addVec("lw18",      1,  0, 18,  1,  0,  1,  1, 1,  0,  0,    0,  0, 3, -1);
      addVec("addi19",    2, 18, 19,  1,  0,  1,  0, 1,  0,  0,    0,  0, 3, 5);

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset ALUsrcA", 32'(aluSrcA), 32'd0);
      checkOutput("reset ALUsrcB", 32'(aluSrcB), 32'd0);
      checkOutput("reset stall", 32'(stallOut), 32'd0);
      checkOutput("reset bubble", 32'(bubbleOut), 32'd0);
      checkOutput("reset stall_cnt", stallCnt, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         sb_t e;
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput({vecs[i].name, " stall"}, 32'(stallOut), 32'(vecs[i].xStall));
         checkOutput({vecs[i].name, " bubble"}, 32'(bubbleOut), 32'(vecs[i].xBubble));
         e.name = vecs[i].name;
         e.a = vecs[i].xA;
         e.b = vecs[i].xB;
         sbQ.push_back(e);
         @(posedge clk);
         #1;
         popCheck();
         if (vecs[i].xCnt >= 0) begin
            checkOutput({vecs[i].name, " stall_cnt"}, stallCnt, 32'(vecs[i].xCnt));
         end
      end

      checkOutput("saturated stall_cnt", 32'(stallCntSat), 32'd3);

      // Reset in the middle of a load-use stall.
      rsId = 5'd1; rtId = 5'd0; rwId = 5'd21;
      useRsId = 1'b1; useRtId = 1'b0; regwrId = 1'b1; loadId = 1'b1; immId = 1'b1; flushIn = 1'b0;
      @(posedge clk);
      #1;
      rsId = 5'd21; rtId = 5'd2; rwId = 5'd22;
      useRsId = 1'b1; useRtId = 1'b1; regwrId = 1'b1; loadId = 1'b0; immId = 1'b0;
      @(negedge clk);
      checkOutput("pre-reset stall", 32'(stallOut), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post-reset stall", 32'(stallOut), 32'd0);
      checkOutput("post-reset bubble", 32'(bubbleOut), 32'd0);
      checkOutput("post-reset ALUsrcA", 32'(aluSrcA), 32'd0);
      checkOutput("post-reset ALUsrcB", 32'(aluSrcB), 32'd0);
      checkOutput("post-reset stall_cnt", stallCnt, 32'd0);
      checkOutput("post-reset sat stall_cnt", 32'(stallCntSat), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("after reset ALUsrcA", 32'(aluSrcA), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
